// File: rtl/return_address_stack_pkg.sv
// Shared types and default configuration for the return-address stack.
// The snapshot/recovery logic is built only when CVA5_RAS_RECOVERY_EN is defined.
package return_address_stack_pkg;

  typedef struct packed {
    int unsigned depth;
    int unsigned snap_depth;
  } ras_cfg_t;

  typedef struct packed {
    ras_cfg_t ras;
  } cva5_config_t;

  localparam cva5_config_t CONFIG = '{ras: '{depth: 8, snap_depth: 4}};

  localparam int unsigned RasPtrW = $clog2(CONFIG.ras.depth);

  // Pointer/count pair captured per predicted branch, sized for the default config.
  typedef struct packed {
    logic [RasPtrW-1:0] rd_ptr;
    logic [RasPtrW:0]   count;
  } ras_snapshot_t;

endpackage

// File: rtl/return_address_stack_if.sv
// Fetch-side interface between the branch predictor (master) and the RAS (slave).
interface return_address_stack_if;
  logic        push;
  logic        pop;
  logic [31:0] new_addr;
  logic [31:0] addr;
  logic        valid;
  logic        branch_retired;
  logic        fetch_recover;

  modport master (
    output push, pop, new_addr, branch_retired, fetch_recover,
    input  addr, valid
  );

  modport slave (
    input  push, pop, new_addr, branch_retired, fetch_recover,
    output addr, valid
  );
endinterface

// File: rtl/return_address_stack_snapshot_fifo.sv
// Synchronous FIFO with flush and a combinational head; push at full is allowed
// when a pop is accepted in the same cycle.
module return_address_stack_snapshot_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic             i_flush,
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_head,
  output logic             o_full,
  output logic             o_empty
);
  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam logic [PtrW:0] CountFull = DEPTH[PtrW:0];

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PtrW-1:0]  r_wr_ptr;
  logic [PtrW-1:0]  r_rd_ptr;
  logic [PtrW:0]    r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_full    = (r_count == CountFull);
  assign o_empty   = (r_count == '0);
  assign o_head    = r_mem[r_rd_ptr];
  assign w_do_pop  = i_pop & ~o_empty;
  assign w_do_push = i_push & (~o_full | w_do_pop);

  always_ff @(posedge i_clk) begin
    if (!i_rst || i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_data;
  end

endmodule

// File: rtl/return_address_stack.sv
// Speculative return-address stack; pointer recovery on fetch flush is built only
// when CVA5_RAS_RECOVERY_EN is defined.
module return_address_stack
  import return_address_stack_pkg::*;
#(
  parameter int unsigned RAS_DEPTH  = CONFIG.ras.depth,
  parameter int unsigned SNAP_DEPTH = CONFIG.ras.snap_depth
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  return_address_stack_if.slave ras
);
  localparam int unsigned   PtrW     = $clog2(RAS_DEPTH);
  localparam logic [PtrW:0] CountMax = RAS_DEPTH[PtrW:0];

  typedef struct packed {
    logic [PtrW-1:0] rd_ptr;
    logic [PtrW:0]   count;
  } snap_t;

  logic [31:0]     r_stack [RAS_DEPTH];
  logic [PtrW-1:0] r_rd_ptr;
  logic [PtrW:0]   r_count;
  logic [PtrW-1:0] w_rd_ptr_d;
  logic [PtrW:0]   w_count_d;
  logic [PtrW-1:0] w_ptr_inc;
  logic [PtrW-1:0] w_ptr_dec;
  logic [PtrW-1:0] w_wr_idx;
  logic            w_wr_en;
  logic            w_recover;
  logic            w_snap_empty;
  snap_t           w_snap_head;

  assign w_ptr_inc = r_rd_ptr + 1'b1;
  assign w_ptr_dec = r_rd_ptr - 1'b1;

  assign ras.addr  = r_stack[r_rd_ptr];
  assign ras.valid = (r_count != '0);

`ifdef CVA5_RAS_RECOVERY_EN
  logic  r_overflow;
  logic  w_snap_full;
  logic  w_snap_req;
  logic  w_enq;
  logic  w_deq;
  snap_t w_snap_cur;

  assign w_recover  = ras.fetch_recover;
  assign w_snap_req = ~w_recover & (ras.push | ras.pop);
  assign w_deq      = ~w_recover & ras.branch_retired;
  assign w_snap_cur = '{rd_ptr: r_rd_ptr, count: r_count};
  // After an overflow, later branches stay untracked until the FIFO drains.
  assign w_enq      = w_snap_req & ~r_overflow & (~w_snap_full | w_deq);

  always_ff @(posedge i_clk) begin
    if (!i_rst)                     r_overflow <= 1'b0;
    else if (w_recover)             r_overflow <= 1'b0;
    else if (w_snap_empty)          r_overflow <= 1'b0;
    else if (w_snap_req && !w_enq)  r_overflow <= 1'b1;
  end

  return_address_stack_snapshot_fifo #(
    .WIDTH ($bits(snap_t)),
    .DEPTH (SNAP_DEPTH)
  ) u_snap_fifo (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_push  (w_enq),
    .i_pop   (w_deq),
    .i_flush (w_recover),
    .i_data  (w_snap_cur),
    .o_head  (w_snap_head),
    .o_full  (w_snap_full),
    .o_empty (w_snap_empty)
  );
`else
  logic w_unused;

  assign w_recover    = 1'b0;
  assign w_snap_empty = 1'b1;
  assign w_snap_head  = '0;
  assign w_unused     = ^{ras.branch_retired, ras.fetch_recover};
`endif

  always_comb begin
    w_rd_ptr_d = r_rd_ptr;
    w_count_d  = r_count;
    w_wr_en    = 1'b0;
    w_wr_idx   = r_rd_ptr;
    if (w_recover) begin
      if (!w_snap_empty) begin
        w_rd_ptr_d = w_snap_head.rd_ptr;
        w_count_d  = w_snap_head.count;
      end
    end else if (ras.push && ras.pop) begin
      // Return-and-call replaces the top in place.
      w_wr_en = 1'b1;
    end else if (ras.push) begin
      w_wr_en    = 1'b1;
      w_wr_idx   = w_ptr_inc;
      w_rd_ptr_d = w_ptr_inc;
      w_count_d  = (r_count == CountMax) ? r_count : r_count + 1'b1;
    end else if (ras.pop) begin
      w_rd_ptr_d = w_ptr_dec;
      w_count_d  = (r_count == '0) ? r_count : r_count - 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_rd_ptr <= '0;
      r_count  <= '0;
      for (int unsigned i = 0; i < RAS_DEPTH; i++) r_stack[i] <= '0;
    end else begin
      r_rd_ptr <= w_rd_ptr_d;
      r_count  <= w_count_d;
      if (w_wr_en) r_stack[w_wr_idx] <= ras.new_addr;
    end
  end

endmodule
